bus_sram_slave: RTL and testbench



---
 rtl/bus_sram_slave_pkg.sv | 26 ++
 rtl/bus_if.sv | 25 ++
 rtl/bus_sram_slave_resp_fifo.sv | 62 ++++++
 rtl/bus_sram_slave.sv | 104 ++++++++++
 tb/tb_bus_sram_slave.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_sram_slave_pkg.sv
// Shared bus types for the data-bus SRAM responder: OCP command/response
// encodings and the response word carried through the response queue.
package bus_sram_slave_pkg;

  typedef logic [31:0] Word;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    WR   = 3'b001,
    RD   = 3'b010
  } Ocp_cmd;

  typedef enum logic [1:0] {
    NULL = 2'b00,
    DVA  = 2'b01,
    ERR  = 2'b11
  } Ocp_resp;

  typedef struct packed {
    Ocp_resp resp;
    Word     data;
  } Slave_resp;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/bus_if.sv
// OCP-style processor data bus between the load/store unit and its slaves.
interface Bus_if;
  import bus_sram_slave_pkg::*;

  Ocp_cmd          MCmd;
  Word             MAddr;
  Word             MData;
  logic [3:0]      MByteEn;
  logic            MRespAccept;
  logic            MReset_n;
  logic            SCmdAccept;
  Ocp_resp         SResp;
  Word             SData;

  modport slave (
    input  MCmd, MAddr, MData, MByteEn, MRespAccept,
    output SCmdAccept, SResp, SData
  );

  modport master (
    output MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
    input  SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/bus_sram_slave_resp_fifo.sv
// Shift-style response queue: entry 0 is always the head, so the head is a
// plain register and slides down on every pop.
module bus_resp_fifo
  import bus_sram_slave_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  Slave_resp i_pushData,
  input  logic      i_pop,
  output Slave_resp o_head,
  output logic      o_empty,
  output logic      o_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] r_count;
  Slave_resp     r_data [DEPTH];
  Slave_resp     w_next [DEPTH];
  logic          w_pop;
  logic          w_push;
  logic [IW-1:0] w_wrIdx;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_data[0];

  // Slots above the occupancy are kept zero, which the zero fill on pop preserves.
  always_comb begin
    w_wrIdx = w_pop ? IW'(r_count - CW'(1)) : IW'(r_count);
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_next[i] = w_pop ? r_data[i + 1] : r_data[i];
    end
    w_next[DEPTH - 1] = w_pop ? '0 : r_data[DEPTH - 1];
    if (w_push) begin
      w_next[w_wrIdx] = i_pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_data <= w_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM responder on the data bus: one in-order response per
// command, with credit-based acceptance so queued responses are never lost.
module bus_sram_slave
  import bus_sram_slave_pkg::*;
#(
  parameter int   MEM_DEPTH    = 1024,
  parameter int   RESP_DEPTH   = 4,
  parameter logic BYTE_ENABLED = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  Bus_if.slave iobus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int OW = $clog2(RESP_DEPTH + 1);

  Word           r_mem [MEM_DEPTH];
  Word           r_rdData;
  logic [OW-1:0] r_outstanding;
  logic          r_s1Valid;
  logic          r_s1IsRd;
  logic          r_s1Err;

  logic          w_cmdXfer;
  logic          w_rspXfer;
  logic          w_inRange;
  logic          w_empty;
  logic          w_full;
  logic [3:0]    w_be;
  logic [AW-1:0] w_addrIdx;
  Slave_resp     w_pushData;
  Slave_resp     w_head;

  // A response popping this cycle frees its credit immediately, so a stalled
  // master sees SCmdAccept rise in the very cycle it accepts a response.
  assign w_rspXfer = !w_empty && iobus.MRespAccept;
  assign w_cmdXfer = rst_n && (iobus.MCmd != IDLE) &&
                     ((r_outstanding < OW'(RESP_DEPTH)) || w_rspXfer);
  assign iobus.SCmdAccept = w_cmdXfer;

  assign w_inRange = (iobus.MAddr < Word'(MEM_DEPTH));
  assign w_addrIdx = iobus.MAddr[AW-1:0];
  assign w_be      = BYTE_ENABLED ? iobus.MByteEn : 4'hF;

  always_ff @(posedge clk) begin
    if (w_cmdXfer && w_inRange) begin
      if (iobus.MCmd == WR) begin
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
          if (w_be[b]) begin
            r_mem[w_addrIdx][8*b +: 8] <= iobus.MData[8*b +: 8];
          end
        end
      end
      if (iobus.MCmd == RD) begin
        r_rdData <= r_mem[w_addrIdx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid     <= 1'b0;
      r_s1IsRd      <= 1'b0;
      r_s1Err       <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_s1Valid <= w_cmdXfer;
      r_s1IsRd  <= (iobus.MCmd == RD);
      r_s1Err   <= !w_inRange;
      case ({w_cmdXfer, w_rspXfer})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_comb begin
    w_pushData.resp = r_s1Err ? ERR : DVA;
    w_pushData.data = (r_s1IsRd && !r_s1Err) ? r_rdData : '0;
  end

  bus_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_respFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (r_s1Valid),
    .i_pushData(w_pushData),
    .i_pop     (iobus.MRespAccept),
    .o_head    (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign iobus.SResp = w_empty ? NULL : w_head.resp;
  assign iobus.SData = w_empty ? '0 : w_head.data;

  // The credit limit guarantees the stage never pushes into a full queue.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(r_s1Valid && w_full && !w_rspXfer));

endmodule

// File: tb/tb_bus_sram_slave.sv
// Randomized bench for bus_sram_slave against a cycle-level transaction model.
module tb_bus_sram_slave;
  import bus_sram_slave_pkg::*;

  localparam int MEM    = 1024;
  localparam int RDEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  Bus_if bus0 ();
  Bus_if bus1 ();

  bus_sram_slave #(.MEM_DEPTH(MEM), .RESP_DEPTH(RDEPTH), .BYTE_ENABLED(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .iobus(bus0.slave));

  bus_sram_slave #(.MEM_DEPTH(16), .RESP_DEPTH(RDEPTH), .BYTE_ENABLED(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .iobus(bus1.slave));

  typedef struct {
    Ocp_resp resp;
    Word     data;
    Word     mask;
    int      cyc;
  } ExpResp;

  ExpResp expQ[$];
  Word    modelMem   [MEM];
  Word    modelKnown [MEM];
  int     testsRun    = 0;
  int     testsFailed = 0;
  int     cycleNo     = 0;
  Word    lastPopData = '0;

  // One bus cycle on dut0: drive, sample before the edge, then advance the model.
  // A response is due on the bus exactly two cycles after its command transferred.
  task automatic step(input Ocp_cmd cmd, input Word addr, input Word data,
                      input logic [3:0] be, input logic respAccept, output logic accepted);
    logic   expVisible, pop, expAcc;
    ExpResp e;
    int     idx;
    @(negedge clk);
    bus0.MCmd = cmd; bus0.MAddr = addr; bus0.MData = data;
    bus0.MByteEn = be; bus0.MRespAccept = respAccept;
    #1;
    expVisible = (expQ.size() > 0) && (cycleNo >= expQ[0].cyc + 2);
    testsRun++;
    if ((bus0.SResp != NULL) !== expVisible) begin
      testsFailed++;
      $display("[TB] FAIL resp_valid cyc=%0d: SResp=%0d, expected valid=%0b", cycleNo, bus0.SResp, expVisible);
    end
    if (expVisible) begin
      testsRun++;
      if (bus0.SResp !== expQ[0].resp) begin
        testsFailed++;
        $display("[TB] FAIL resp_code cyc=%0d: got %0d, expected %0d", cycleNo, bus0.SResp, expQ[0].resp);
      end
      testsRun++;
      if ((bus0.SData & expQ[0].mask) !== (expQ[0].data & expQ[0].mask)) begin
        testsFailed++;
        $display("[TB] FAIL resp_data cyc=%0d: got %h, expected %h (mask %h)", cycleNo, bus0.SData, expQ[0].data, expQ[0].mask);
      end
    end
    pop    = expVisible && respAccept;
    expAcc = (cmd != IDLE) && ((expQ.size() < RDEPTH) || pop);
    testsRun++;
    if (bus0.SCmdAccept !== expAcc) begin
      testsFailed++;
      $display("[TB] FAIL cmd_accept cyc=%0d: got %b, expected %b", cycleNo, bus0.SCmdAccept, expAcc);
    end
    if (pop) begin
      lastPopData = bus0.SData;
      void'(expQ.pop_front());
    end
    if (expAcc) begin
      e.cyc  = cycleNo;
      e.mask = '1;
      e.resp = DVA;
      e.data = '0;
      if (addr >= Word'(MEM)) begin
        e.resp = ERR;
      end else begin
        idx = int'(addr);
        if (cmd == RD) begin
          e.data = modelMem[idx];
          e.mask = modelKnown[idx];
        end else if (cmd == WR) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
              modelMem[idx][8*b +: 8]   = data[8*b +: 8];
              modelKnown[idx][8*b +: 8] = 8'hFF;
            end
          end
        end
      end
      expQ.push_back(e);
    end
    accepted = expAcc;
    cycleNo++;
  endtask

  // Master behaviour: hold a command until it transfers, within a cycle budget.
  task automatic issue(input Ocp_cmd cmd, input Word addr, input Word data,
                       input logic [3:0] be, input logic respAccept);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      step(cmd, addr, data, be, respAccept, acc);
    end
    if (!acc) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL issue_timeout: accepted=%b, expected 1", acc);
    end
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < RDEPTH + 4; n++) begin
      step(IDLE, '0, '0, 4'h0, 1'b1, acc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.MCmd = RD; bus0.MAddr = '0; bus0.MData = '0; bus0.MByteEn = 4'hF;
    bus0.MRespAccept = 1'b0; bus0.MReset_n = 1'b1;
    bus1.MCmd = IDLE; bus1.MAddr = '0; bus1.MData = '0; bus1.MByteEn = 4'h0;
    bus1.MRespAccept = 1'b1; bus1.MReset_n = 1'b1;
    #3;
    testsRun++;
    if (bus0.SResp !== NULL) begin
      testsFailed++; $display("[TB] FAIL reset_sresp: got %0d, expected NULL", bus0.SResp);
    end
    testsRun++;
    if (bus0.SData !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL reset_sdata: got %h, expected 0", bus0.SData);
    end
    testsRun++;
    if (bus0.SCmdAccept !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_accept: got %b, expected 0", bus0.SCmdAccept);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus0.MCmd = IDLE;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    issue(WR, 32'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(RD, 32'd5, 32'h0, 4'hF, 1'b1);
    drain();
    testsRun++;
    if (lastPopData !== 32'hDEADBEEF) begin
      testsFailed++; $display("[TB] FAIL write_read: got %h, expected deadbeef", lastPopData);
    end
  endtask

  task automatic test_byte_write();
    issue(WR, 32'd9, 32'h11223344, 4'hF, 1'b1);
    issue(WR, 32'd9, 32'h00AA0000, 4'b0100, 1'b1);
    issue(RD, 32'd9, 32'h0, 4'hF, 1'b1);
    drain();
    testsRun++;
    if (lastPopData !== 32'h11AA3344) begin
      testsFailed++; $display("[TB] FAIL byte_write: got %h, expected 11aa3344", lastPopData);
    end
    issue(WR, 32'd9, 32'hFFFFFFFF, 4'b0000, 1'b1);
    issue(RD, 32'd9, 32'h0, 4'hF, 1'b1);
    drain();
    testsRun++;
    if (lastPopData !== 32'h11AA3344) begin
      testsFailed++; $display("[TB] FAIL byte_none: got %h, expected 11aa3344", lastPopData);
    end
  endtask

  // dut1 ignores byte enables, so the partial write overwrites the whole word.
  task automatic test_byte_disabled();
    Ocp_cmd  cmds [3];
    Word     datas [3];
    Word     got[$];
    Ocp_resp gotResp[$];
    cmds[0] = WR; cmds[1] = WR; cmds[2] = RD;
    datas[0] = 32'h11223344; datas[1] = 32'h00AA0000; datas[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus1.MCmd = cmds[i]; bus1.MAddr = 32'd3; bus1.MData = datas[i];
      bus1.MByteEn = (i == 1) ? 4'b0100 : 4'hF; bus1.MRespAccept = 1'b1;
      #1;
      testsRun++;
      if (bus1.SCmdAccept !== 1'b1) begin
        testsFailed++; $display("[TB] FAIL nobe_accept[%0d]: got %b, expected 1", i, bus1.SCmdAccept);
      end
      if (bus1.SResp != NULL) begin got.push_back(bus1.SData); gotResp.push_back(bus1.SResp); end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus1.MCmd = IDLE;
      #1;
      if (bus1.SResp != NULL) begin got.push_back(bus1.SData); gotResp.push_back(bus1.SResp); end
    end
    testsRun++;
    if (got.size() != 3) begin
      testsFailed++; $display("[TB] FAIL nobe_count: got %0d responses, expected 3", got.size());
    end else begin
      testsRun++;
      if (got[2] !== 32'h00AA0000 || gotResp[2] !== DVA) begin
        testsFailed++; $display("[TB] FAIL nobe_data: got %h/%0d, expected 00aa0000/DVA", got[2], gotResp[2]);
      end
    end
  endtask

  task automatic test_throughput();
    logic acc;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(WR, Word'(i / 2), $urandom, 4'hF, 1'b1, acc);
      else            step(RD, Word'(i / 2), 32'h0, 4'hF, 1'b1, acc);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic acc;
    int   dutAcc;
    dutAcc = 0;
    for (int j = 0; j < 6; j++) begin
      step(RD, Word'(j), 32'h0, 4'hF, 1'b0, acc);
      if (bus0.SCmdAccept === 1'b1) dutAcc++;
      if (acc) continue;
    end
    testsRun++;
    if (dutAcc != RDEPTH) begin
      testsFailed++; $display("[TB] FAIL bp_count: got %0d accepts, expected %0d", dutAcc, RDEPTH);
    end
    step(RD, 32'd4, 32'h0, 4'hF, 1'b1, acc);
    testsRun++;
    if (bus0.SCmdAccept !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL bp_release: got %b, expected 1", bus0.SCmdAccept);
    end
    step(RD, 32'd5, 32'h0, 4'hF, 1'b0, acc);
    issue(RD, 32'd5, 32'h0, 4'hF, 1'b1);
    drain();
  endtask

  task automatic test_out_of_range();
    Word saved;
    saved = modelMem[0];
    issue(RD, Word'(MEM), 32'h0, 4'hF, 1'b1);
    issue(WR, Word'(MEM), 32'hFFFFFFFF, 4'hF, 1'b1);
    issue(RD, Word'(MEM + 100), 32'h0, 4'hF, 1'b1);
    issue(RD, 32'd0, 32'h0, 4'hF, 1'b1);
    drain();
    testsRun++;
    if (lastPopData !== saved) begin
      testsFailed++; $display("[TB] FAIL oor_alias: got %h, expected %h", lastPopData, saved);
    end
  endtask

  task automatic test_random();
    logic   acc;
    Ocp_cmd cmd;
    Word    addr;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0:       cmd = IDLE;
        1:       cmd = WR;
        default: cmd = RD;
      endcase
      addr = ($urandom_range(0, 7) == 0) ? Word'(MEM + $urandom_range(0, 3)) : Word'($urandom_range(0, 15));
      step(cmd, addr, $urandom, 4'($urandom), ($urandom_range(0, 3) != 0), acc);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    logic acc;
    step(RD, 32'd1, 32'h0, 4'hF, 1'b0, acc);
    step(WR, 32'd20, $urandom, 4'hF, 1'b0, acc);
    step(RD, 32'd3, 32'h0, 4'hF, 1'b0, acc);
    step(IDLE, '0, '0, 4'h0, 1'b0, acc);
    step(IDLE, '0, '0, 4'h0, 1'b0, acc);
    @(negedge clk);
    bus0.MCmd = RD; bus0.MAddr = 32'd5; bus0.MRespAccept = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (bus0.SResp !== NULL || bus0.SData !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL midreset_resp: got %0d/%h, expected NULL/0", bus0.SResp, bus0.SData);
    end
    testsRun++;
    if (bus0.SCmdAccept !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL midreset_accept: got %b, expected 0", bus0.SCmdAccept);
    end
    expQ.delete();
    bus0.MCmd = IDLE;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(RD, 32'd5, 32'h0, 4'hF, 1'b1);
    drain();
    for (int j = 0; j < RDEPTH; j++) begin
      step(RD, 32'd20, 32'h0, 4'hF, 1'b0, acc);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) begin
      modelMem[i]   = '0;
      modelKnown[i] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_write();
    test_byte_disabled();
    test_throughput();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
